// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the processor's dmem port. Decodes each word
//   address into one of three regions:
//   - a word-addressed synchronous RAM
//   - an MMIO page holding a cycle counter, an LED register and a TX FIFO
//   - unmapped space, which reads 0 and drops stores
//   The TX FIFO drains to a serial transmitter over tx_valid/tx_ready.
//
// Handshake (TX side): tx_valid is high whenever the FIFO holds a byte, and
//   tx_data is the head byte in that same cycle (first-word-fall-through).
//   A byte transfers, and is popped, on every rising edge where
//   tx_valid && tx_ready. tx_valid never depends on tx_ready.
//
// Ports
//   clock         in   1          rising-edge clock
//   reset         in   1          synchronous, active-low reset
//   address_dmem  in   32         word address
//   data          in   32         store data
//   wren          in   1          store enable
//   q_dmem        out  32         read data, one cycle after the address edge
//   tx_data       out  8          FIFO head byte (0 when empty)
//   tx_valid      out  1          FIFO non-empty
//   tx_ready      in   1          consumer accepts tx_data
//   leds          out  LED_WIDTH  LED register
module dmem_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int LED_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          address_dmem,
   input  logic [31:0]          data,
   input  logic                 wren,
   output logic [31:0]          q_dmem,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [LED_WIDTH-1:0] leds
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [3:0] REG_CYCLE  = 4'h0;
   localparam logic [3:0] REG_LED    = 4'h1;
   localparam logic [3:0] REG_TXDATA = 4'h2;
   localparam logic [3:0] REG_STATUS = 4'h3;

   // ---------------- decode ----------------
   logic                  w_sel_mmio;
   logic                  w_sel_ram;
   logic [3:0]            w_reg;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic                  w_store;

   assign w_sel_mmio = (address_dmem[31:12] == 20'hFFFFF);
   assign w_sel_ram  = (address_dmem[31:ADDR_WIDTH] == '0);
   assign w_reg      = address_dmem[3:0];
   assign w_ram_addr = address_dmem[ADDR_WIDTH-1:0];
   // Stores presented while reset is asserted must not land anywhere.
   assign w_store    = wren & reset;

   // ---------------- RAM ----------------
   // Kept free of reset so it maps onto block RAM. The read port samples the
   // pre-edge contents, which gives read-first behaviour on a same-word write.
   logic [31:0] r_ram [0:(1<<ADDR_WIDTH)-1];
   logic [31:0] r_ram_q;

   always_ff @(posedge clock) begin
      if (w_store && w_sel_ram) begin
         r_ram[w_ram_addr] <= data;
      end
      r_ram_q <= r_ram[w_ram_addr];
   end

   // ---------------- cycle counter and LED ----------------
   logic [31:0]          r_cycle;
   logic [LED_WIDTH-1:0] r_led;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cycle <= '0;
         r_led   <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_store && w_sel_mmio && (w_reg == REG_LED)) begin
            r_led <= data[LED_WIDTH-1:0];
         end
      end
   end

   assign leds = r_led;

   // ---------------- TX FIFO ----------------
   logic [7:0]       r_fifo [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;

   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_accept;
   logic w_ovf_set;
   logic w_ovf_clr;

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_push    = w_store && w_sel_mmio && (w_reg == REG_TXDATA);
   assign w_pop     = tx_valid && tx_ready;
   // A pop on the same edge frees the slot the push needs, even when full.
   assign w_accept  = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && !w_accept;
   assign w_ovf_clr = w_store && w_sel_mmio && (w_reg == REG_STATUS) && data[2];

   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_fifo[r_wr_ptr] <= data[7:0];
      end
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // Set has priority over a clear landing on the same edge.
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign tx_valid = (r_count != '0);
   assign tx_data  = tx_valid ? r_fifo[r_rd_ptr] : 8'h00;

   // ---------------- read path ----------------
   // Non-RAM read data is registered here with reset; r_src_ram picks which
   // register drives q_dmem, so reset forces q_dmem to 0 without touching RAM.
   logic [31:0] w_mmio_rdata;
   logic [31:0] r_mmio_q;
   logic        r_src_ram;

   always_comb begin
      w_mmio_rdata = '0;
      if (w_sel_mmio) begin
         case (w_reg)
            REG_CYCLE:  w_mmio_rdata = r_cycle;
            REG_LED:    w_mmio_rdata[LED_WIDTH-1:0] = r_led;
            REG_STATUS: begin
               w_mmio_rdata[8 +: CNT_W] = r_count;
               w_mmio_rdata[2]          = r_ovf;
               w_mmio_rdata[1]          = w_full;
               w_mmio_rdata[0]          = ~tx_valid;
            end
            default:    w_mmio_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_mmio_q  <= '0;
         r_src_ram <= 1'b0;
      end else begin
         r_mmio_q  <= w_mmio_rdata;
         r_src_ram <= w_sel_ram;
      end
   end

   assign q_dmem = r_src_ram ? r_ram_q : r_mmio_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int LW    = 16;

  // ---------------- clock / DUT ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   address_dmem;
  logic [31:0]   data;
  logic          wren;
  logic [31:0]   q_dmem;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [LW-1:0] leds;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .LED_WIDTH(LW)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .leds         (leds)
  );

  // ---------------- counters ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram   [0:(1<<AW)-1];
  bit          m_known [0:(1<<AW)-1];
  logic [31:0] m_q;
  bit          m_q_known;
  logic [31:0] m_cyc;
  logic [15:0] m_led;
  logic [7:0]  exp_q[$];      // expected FIFO contents, head first
  bit          m_ovf;
  bit          m_init = 1'b0;
  logic [7:0]  obs_q[$];      // bytes the DUT handed over

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One rising edge of the model, using the inputs held across that edge.
  task automatic model_edge(input bit rst_n, input logic [31:0] a, input logic [31:0] d,
                            input bit we, input bit rdy);
    bit          is_mmio;
    bit          is_ram;
    logic [3:0]  off;
    logic [31:0] rv;
    bit          rk;
    bit          pop;
    bit          push;
    bit          room;
    int          n;
    if (!rst_n) begin
      m_q = 32'h0; m_q_known = 1'b1; m_cyc = 32'h0; m_led = 16'h0;
      exp_q.delete(); m_ovf = 1'b0; m_init = 1'b1;
      return;
    end
    is_mmio = (a[31:12] == 20'hFFFFF);
    is_ram  = (a < 32'(1 << AW));
    off     = a[3:0];
    rv      = 32'h0;
    rk      = 1'b1;
    n       = exp_q.size();
    if (is_ram) begin
      rv = m_ram[a[AW-1:0]];
      rk = m_known[a[AW-1:0]];
    end else if (is_mmio) begin
      if (off == 4'd0) rv = m_cyc;
      else if (off == 4'd1) rv = {16'h0, m_led};
      else if (off == 4'd3) rv = 32'(n * 256 + (m_ovf ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
    end
    pop  = (n != 0) && rdy;
    push = we && is_mmio && (off == 4'd2);
    room = (n < DEPTH) || pop;
    if (pop) void'(exp_q.pop_front());
    if (push && room) exp_q.push_back(d[7:0]);
    if (push && !room) m_ovf = 1'b1;
    else if (we && is_mmio && off == 4'd3 && d[2]) m_ovf = 1'b0;
    if (we && is_mmio && off == 4'd1) m_led = d[15:0];
    if (we && is_ram) begin
      m_ram[a[AW-1:0]]   = d;
      m_known[a[AW-1:0]] = 1'b1;
    end
    m_cyc     = m_cyc + 32'd1;
    m_q       = rv;
    m_q_known = rk;
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare_outputs();
    if (!m_init) return;
    if (m_q_known) check("q_dmem", q_dmem, m_q);
    check("leds", {16'h0, leds}, {16'h0, m_led});
    check("tx_valid", {31'h0, tx_valid}, {31'h0, exp_q.size() != 0});
    check("tx_data", {24'h0, tx_data}, {24'h0, (exp_q.size() != 0) ? exp_q[0] : 8'h00});
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit rst_n, input logic [31:0] a, input logic [31:0] d,
                       input bit we, input bit rdy);
    reset        = rst_n;
    address_dmem = a;
    data         = d;
    wren         = we;
    tx_ready     = rdy;
    #1;
    if (rst_n && tx_valid === 1'b1 && tx_ready) obs_q.push_back(tx_data);
    @(posedge clock);
    model_edge(rst_n, a, d, we, rdy);
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b1, 32'h8000_0000, 32'h0, 1'b0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) m_known[i] = 1'b0;

    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset_q", q_dmem, 32'h0);
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);

    // RAM write, read-first on same-word write
    cycle(1'b1, 32'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    cycle(1'b1, 32'd5, 32'h1, 1'b1, 1'b0);
    check("ram_read_first", q_dmem, 32'hDEADBEEF);
    cycle(1'b1, 32'd5, 32'h0, 1'b0, 1'b0);
    check("ram_new_value", q_dmem, 32'h1);
    cycle(1'b1, 32'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    cycle(1'b1, 32'd5, 32'h0, 1'b0, 1'b0);
    check("ram_read", q_dmem, 32'hDEADBEEF);

    // cycle counter restarts from reset
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hFFFFF000, 32'h0, 1'b0, 1'b0);
      check($sformatf("cycle_%0d", i), q_dmem, 32'(i));
    end

    // overflow, clear, ordered drain
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'hFFFFF002, 32'h41 + 32'(i), 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFFF003, 32'h0, 1'b0, 1'b0);
    check("status_full_ovf", q_dmem, 32'h0806);
    cycle(1'b1, 32'hFFFFF003, 32'h4, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFFF003, 32'h0, 1'b0, 1'b0);
    check("status_ovf_clr", q_dmem, 32'h0802);
    obs_q.delete();
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("drain_count", 32'(obs_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      check($sformatf("drain_byte_%0d", i), {24'h0, obs_q[i]}, 32'h41 + 32'(i));
    check("drain_empty", {31'h0, tx_valid}, 32'h0);
    cycle(1'b1, 32'hFFFFF003, 32'h0, 1'b0, 1'b0);
    check("status_empty", q_dmem, 32'h0001);

    // push onto a full FIFO while it pops
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'hFFFFF002, 32'h50 + 32'(i), 1'b1, 1'b0);
    obs_q.delete();
    cycle(1'b1, 32'hFFFFF002, 32'h5A, 1'b1, 1'b1);
    cycle(1'b1, 32'hFFFFF003, 32'h0, 1'b0, 1'b0);
    check("status_full_no_ovf", q_dmem, 32'h0802);
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("pp_count", 32'(obs_q.size()), 32'd9);
    if (obs_q.size() == 9) begin
      check("pp_first", {24'h0, obs_q[0]}, 32'h50);
      check("pp_last", {24'h0, obs_q[8]}, 32'h5A);
    end

    // LED and unmapped space
    cycle(1'b1, 32'hFFFFF001, 32'h12345, 1'b1, 1'b0);
    check("leds_value", {16'h0, leds}, 32'h2345);
    cycle(1'b1, 32'hFFFFF001, 32'h0, 1'b0, 1'b0);
    check("led_read", q_dmem, 32'h2345);
    cycle(1'b1, 32'h0, 32'h0BADF00D, 1'b1, 1'b0);
    cycle(1'b1, 32'h0001_0000, 32'hFFFFFFFF, 1'b1, 1'b0);
    cycle(1'b1, 32'h0001_0000, 32'h0, 1'b0, 1'b0);
    check("unmapped_read", q_dmem, 32'h0);
    cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    check("unmapped_no_alias", q_dmem, 32'h0BADF00D);

    // mid-traffic reset with a store presented
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFFFFF002, 32'h60 + 32'(i), 1'b1, 1'b0);
    cycle(1'b0, 32'd5, 32'h11111111, 1'b1, 1'b1);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_leds", {16'h0, leds}, 32'h0);
    check("rst_q", q_dmem, 32'h0);
    cycle(1'b1, 32'hFFFFF000, 32'h0, 1'b0, 1'b0);
    check("rst_cycle", q_dmem, 32'h0);
    cycle(1'b1, 32'd5, 32'h0, 1'b0, 1'b0);
    check("rst_ram_kept", q_dmem, 32'hDEADBEEF);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit          rst_n;
      bit          we;
      bit          rdy;
      logic [31:0] a;
      int          k;
      rst_n = ($urandom_range(0, 99) != 0);
      k     = $urandom_range(0, 9);
      if (k <= 3)      a = 32'($urandom_range(0, 15));
      else if (k == 4) a = 32'($urandom_range(0, (1 << AW) - 1));
      else if (k <= 8) a = 32'hFFFFF000 | 32'(($urandom_range(0, 1) != 0) ? 2 : $urandom_range(0, 15));
      else             a = $urandom | 32'h0000_1000;
      we  = ($urandom_range(0, 1) != 0);
      rdy = ((i / 200) % 2 != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) != 0);
      cycle(rst_n, a, $urandom, we, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
